// File: rtl/mem_sram_ctrl.sv
// MEM-stage data-memory controller: each 32-bit load/store becomes two 16-bit SRAM accesses,
// stalling the pipeline via ready. Define MEM_READ_CACHE_EN to add a one-entry load cache.
module mem_sram_ctrl #(
  parameter int unsigned BASE_ADDR     = 1024,
  parameter int unsigned ACCESS_CYCLES = 2,
  parameter int unsigned SRAM_AW       = 18
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mem_r_en,
  input  logic               mem_w_en,
  input  logic [31:0]        alu_result,
  input  logic [31:0]        st_val,
  output logic               ready,
  output logic [31:0]        rdata,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_we_n
);

  localparam int unsigned WA_W  = SRAM_AW - 1;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] LAST_PHASE = CNT_W'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WA_W-1:0]    wa_q, wa_d, wa_c;
  logic [31:0]        st_q, st_d;
  logic               store_q, store_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [SRAM_AW-1:0] addr_q, addr_d;
  logic [15:0]        dq_q, dq_d;
  logic               oe_q, oe_d;
  logic               we_n_q, we_n_d;
  logic               req, last, hit;

  assign req  = mem_r_en | mem_w_en;
  assign wa_c = WA_W'((alu_result - 32'(BASE_ADDR)) >> 2);
  assign last = (cnt_q == LAST_PHASE);

`ifdef MEM_READ_CACHE_EN
  logic            cache_valid_q, cache_valid_d;
  logic [WA_W-1:0] cache_tag_q, cache_tag_d;
  logic [31:0]     cache_data_q, cache_data_d;

  // A load hit completes in IDLE without touching the SRAM
  assign hit   = (state_q == IDLE) && mem_r_en && !mem_w_en && cache_valid_q &&
                 (cache_tag_q == wa_c);
  assign rdata = hit ? cache_data_q : rdata_q;

  always_comb begin
    cache_valid_d = cache_valid_q;
    cache_tag_d   = cache_tag_q;
    cache_data_d  = cache_data_q;
    if (state_q == DONE) begin
      if (!store_q) begin
        cache_valid_d = 1'b1;
        cache_tag_d   = wa_q;
        cache_data_d  = rdata_q;
      end else if (cache_valid_q && (cache_tag_q == wa_q)) begin
        cache_data_d  = st_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cache_valid_q <= 1'b0;
      cache_tag_q   <= '0;
      cache_data_q  <= '0;
    end else begin
      cache_valid_q <= cache_valid_d;
      cache_tag_q   <= cache_tag_d;
      cache_data_q  <= cache_data_d;
    end
  end
`else
  assign hit   = 1'b0;
  assign rdata = rdata_q;
`endif

  assign ready       = !reset || (state_q == DONE) || ((state_q == IDLE) && (!req || hit));
  assign sram_addr   = addr_q;
  assign sram_dq_out = dq_q;
  assign sram_dq_oe  = oe_q;
  assign sram_we_n   = we_n_q;

  // Next state; SRAM pins are registered from the state being entered so they line up with it
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wa_d    = wa_q;
    st_d    = st_q;
    store_d = store_q;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    dq_d    = dq_q;
    oe_d    = 1'b0;
    we_n_d  = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (req && !hit) begin
          wa_d    = wa_c;
          st_d    = st_val;
          store_d = mem_w_en;
          cnt_d   = '0;
          state_d = LO;
          addr_d  = {wa_c, 1'b0};
          we_n_d  = !mem_w_en;
          oe_d    = mem_w_en;
          if (mem_w_en) dq_d = st_val[15:0];
        end
      end
      LO: begin
        we_n_d = !store_q;
        oe_d   = store_q;
        if (last) begin
          cnt_d   = '0;
          state_d = HI;
          addr_d  = {wa_q, 1'b1};
          if (store_q) dq_d = st_q[31:16];
          else         rdata_d[15:0] = sram_dq_in;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HI: begin
        if (last) begin
          cnt_d   = '0;
          state_d = DONE;
          if (!store_q) rdata_d[31:16] = sram_dq_in;
        end else begin
          we_n_d = !store_q;
          oe_d   = store_q;
          cnt_d  = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wa_q    <= '0;
      st_q    <= '0;
      store_q <= 1'b0;
      rdata_q <= '0;
      addr_q  <= '0;
      dq_q    <= '0;
      oe_q    <= 1'b0;
      we_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wa_q    <= wa_d;
      st_q    <= st_d;
      store_q <= store_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      dq_q    <= dq_d;
      oe_q    <= oe_d;
      we_n_q  <= we_n_d;
    end
  end

endmodule
